// File: rtl/mau_pkg.sv
// Shared encodings and helpers for the data-RAM access unit (mem_access_unit).
package mau_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    RESP  = 2'b11
  } state_e;

  // Encoding 2'b11 carries no meaning of its own and behaves as a word access.
  function automatic size_e norm_size(input logic [1:0] sz);
    case (sz)
      2'b00:   return SZ_BYTE;
      2'b01:   return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

  function automatic logic is_misaligned(input size_e sz, input logic [1:0] off);
    case (sz)
      SZ_HALF: return off[0];
      SZ_WORD: return |off;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Pipeline request/response channel plus the RAM port; slave is the unit, master is the pipeline/RAM side.
interface mem_access_unit_if
  import mau_pkg::*;
#(
  parameter int MEM_AW = 16
);
  logic              req_valid;
  logic              req_ready;
  logic              req_rw;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [MEM_AW+1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_error;
  logic [MEM_AW-1:0] mem_address;
  logic [DATA_W-1:0] mem_data_in;
  logic              mem_rw;
  logic              mem_en;
  logic [DATA_W-1:0] mem_data_out;
  logic              mem_miss;

  modport slave (
    input  req_valid, req_rw, req_size, req_signed, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_error,
    output mem_address, mem_data_in, mem_rw, mem_en,
    input  mem_data_out, mem_miss
  );

  modport master (
    output req_valid, req_rw, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_error,
    input  mem_address, mem_data_in, mem_rw, mem_en,
    output mem_data_out, mem_miss
  );
endinterface

// File: rtl/mau_lane_align.sv
// Combinational lane logic: extracts/extends a load lane and merges a sub-word store into a read word.
module mau_lane_align
  import mau_pkg::*;
(
  input  logic [DATA_W-1:0] word,
  input  logic [1:0]        offset,
  input  size_e             size,
  input  logic              is_signed,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] load_val,
  output logic [DATA_W-1:0] store_word
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b     = word[{offset, 3'b000} +: 8];
    lane_h     = offset[1] ? word[31:16] : word[15:0];
    load_val   = word;
    store_word = wdata;
    case (size)
      SZ_BYTE: begin
        load_val   = {{24{is_signed & lane_b[7]}}, lane_b};
        store_word = word;
        store_word[{offset, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        load_val   = {{16{is_signed & lane_h[15]}}, lane_h};
        store_word = offset[1] ? {wdata[15:0], word[15:0]} : {word[31:16], wdata[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front end of the data RAM: load/word store 2 cycles, sub-word store 3, +1 per mem_miss; one request in flight.
// MAU_MISALIGN_TRAP_EN: when defined, misaligned requests return resp_error without a RAM access; otherwise they are force-aligned.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int MEM_AW = 16
)(
  input logic               Clk,
  input logic               Rst,
  mem_access_unit_if.slave  bus
);

  state_e            state;
  size_e             r_size;
  logic [1:0]        r_off;
  logic              r_rw;
  logic              r_signed;
  logic [DATA_W-1:0] r_wdata;

  logic              req_ready;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_error;
  logic [MEM_AW-1:0] mem_address;
  logic [DATA_W-1:0] mem_data_in;
  logic              mem_rw;
  logic              mem_en;

  size_e             acc_size;
  logic [MEM_AW+1:0] acc_addr;
  logic              acc_trap;
  logic [DATA_W-1:0] load_val;
  logic [DATA_W-1:0] store_word;

  always_comb begin
    acc_size = norm_size(bus.req_size);
    acc_addr = bus.req_addr;
`ifdef MAU_MISALIGN_TRAP_EN
    acc_trap = is_misaligned(acc_size, bus.req_addr[1:0]);
`else
    acc_trap = 1'b0;
    if (acc_size == SZ_HALF)
      acc_addr[0] = 1'b0;
    else if (acc_size == SZ_WORD)
      acc_addr[1:0] = 2'b00;
`endif
  end

  // The RAM read is asynchronous, so lanes are taken straight from mem_data_out in READ.
  mau_lane_align u_lane_align (
    .word       (bus.mem_data_out),
    .offset     (r_off),
    .size       (r_size),
    .is_signed  (r_signed),
    .wdata      (r_wdata),
    .load_val   (load_val),
    .store_word (store_word)
  );

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state       <= IDLE;
      r_size      <= SZ_BYTE;
      r_off       <= 2'b00;
      r_rw        <= 1'b0;
      r_signed    <= 1'b0;
      r_wdata     <= '0;
      req_ready   <= 1'b1;
      resp_valid  <= 1'b0;
      resp_rdata  <= '0;
      resp_error  <= 1'b0;
      mem_address <= '0;
      mem_data_in <= '0;
      mem_rw      <= 1'b0;
      mem_en      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            r_size    <= acc_size;
            r_off     <= acc_addr[1:0];
            r_rw      <= bus.req_rw;
            r_signed  <= bus.req_signed;
            r_wdata   <= bus.req_wdata;
            req_ready <= 1'b0;
            if (acc_trap) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_error <= 1'b1;
              resp_rdata <= '0;
            end else if (bus.req_rw && acc_size == SZ_WORD) begin
              state       <= WRITE;
              mem_en      <= 1'b1;
              mem_rw      <= 1'b1;
              mem_address <= acc_addr[MEM_AW+1:2];
              mem_data_in <= bus.req_wdata;
            end else begin
              state       <= READ;
              mem_en      <= 1'b1;
              mem_rw      <= 1'b0;
              mem_address <= acc_addr[MEM_AW+1:2];
            end
          end
        end
        READ: begin
          if (!bus.mem_miss) begin
            if (r_rw) begin
              state       <= WRITE;
              mem_rw      <= 1'b1;
              mem_data_in <= store_word;
            end else begin
              state      <= RESP;
              mem_en     <= 1'b0;
              resp_valid <= 1'b1;
              resp_rdata <= load_val;
            end
          end
        end
        WRITE: begin
          if (!bus.mem_miss) begin
            state      <= RESP;
            mem_en     <= 1'b0;
            mem_rw     <= 1'b0;
            resp_valid <= 1'b1;
            resp_rdata <= '0;
          end
        end
        RESP: begin
          state      <= IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          resp_rdata <= '0;
          resp_error <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready   = req_ready;
  assign bus.resp_valid  = resp_valid;
  assign bus.resp_rdata  = resp_rdata;
  assign bus.resp_error  = resp_error;
  assign bus.mem_address = mem_address;
  assign bus.mem_data_in = mem_data_in;
  assign bus.mem_rw      = mem_rw;
  assign bus.mem_en      = mem_en;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Pipeline-side front end of the data RAM. Accepts byte, halfword and word load/store requests from the MEM pipeline stage.
- Converts byte addresses to the RAM's 16-bit word address.
- Performs read-modify-write for sub-word stores, because the RAM writes whole words only.
- Sign- or zero-extends sub-word loads and returns a single-cycle response pulse.
- Drives the RAM's address, data_in, rw and en inputs; consumes its data_out (combinational read) and miss.

Parameters:
- MEM_AW, 16, word-address width of the RAM.
- DATA_W, 32, data width. Fixed at 32; other values are unsupported.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept; high only in IDLE.
- req_rw  in  1  0 = load, 1 = store.
- req_size  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
- req_signed  in  1  sign-extend a sub-word load.
- req_addr  in  MEM_AW+2  byte address.
- req_wdata  in  32  store data; sub-word store data in the low bits.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  load result; 0 for stores and errors.
- resp_error  out  1  misaligned request, valid with resp_valid.
- mem_address  out  MEM_AW  word address = req_addr[MEM_AW+1:2].
- mem_data_in  out  32  write word.
- mem_rw  out  1  1 = write.
- mem_en  out  1  access enable.
- mem_data_out  in  32  read word, valid in the same cycle (async read).
- mem_miss  in  1  access failed; retry.

Behaviour:
- Byte ordering is little-endian: byte offset k occupies bits 8k+7:8k. Halfword offset 0 is bits 15:0, offset 2 is bits 31:16.
- Reset values: state = IDLE, req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_error = 0, mem_en = 0, mem_rw = 0, mem_address = 0, mem_data_in = 0. All internal registers are cleared.
- A request is accepted when req_valid and req_ready are both high at a rising edge. On acceptance, addr, size, rw, signed and wdata are registered; later changes on the req_* inputs are ignored.
- Misaligned requests:
  - A half at addr[0] = 1 is misaligned.
  - A word with addr[1:0] != 0 is misaligned.
  - A misaligned request goes IDLE -> RESP with resp_error = 1 and makes no RAM access (mem_en stays 0).
- States:
  - IDLE: req_ready = 1, mem_en = 0.
    - Aligned load or sub-word store -> READ.
    - Aligned word store -> WRITE.
  - READ: mem_en = 1, mem_rw = 0, mem_address driven.
    - If mem_miss: stay in READ.
    - Else: latch mem_data_out at the edge. Load -> RESP. Store -> WRITE.
  - WRITE: mem_en = 1, mem_rw = 1.
    - mem_data_in = req_wdata for a word store; otherwise the read word with the addressed lane replaced by req_wdata[7:0] or req_wdata[15:0].
    - If mem_miss: stay in WRITE. Else -> RESP.
  - RESP: resp_valid = 1 for exactly one cycle, then -> IDLE.
    - resp_rdata = extracted lane, zero- or sign-extended, or the full word.
    - resp_error is as decided at acceptance.
- Latencies, counted from the acceptance edge to the resp_valid cycle:
  - load: 2 cycles;
  - word store: 2 cycles;
  - sub-word store: 3 cycles;
  - misaligned: 1 cycle;
  - each mem_miss cycle adds 1 cycle.
- Back-to-back requests: the next request is accepted at the earliest in the cycle after RESP (the IDLE cycle). There is no overlap.
- Reset mid-operation: the unit returns to IDLE immediately. A WRITE in flight may or may not have committed; no response is issued.
- mem_address and mem_data_in are held stable for every cycle in which mem_en = 1.

Optional Feature:
- Macro: MAU_MISALIGN_TRAP_EN.
- Defined: misaligned requests are trapped as described above (resp_error = 1, no RAM access).
- Undefined: resp_error is tied to 0. Misaligned addresses are force-aligned by clearing addr[0] for halves and addr[1:0] for words, then executed normally.

Decomposition:
- Package mau_pkg:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - state encoding IDLE, READ, WRITE, RESP;
  - constant DATA_W = 32.
- Sub-module mau_lane_align (combinational):
  - inputs: word, offset, size, signed, wdata;
  - outputs: the extended load value and the merged store word.
- The FSM stays in mem_access_unit.

Test Plan:
- Word store then word load at 0x0010: wdata 0xDEADBEEF -> mem_address 0x0004 with mem_rw = 1. The following load returns resp_rdata 0xDEADBEEF two cycles after acceptance.
- Byte store 0xAA at 0x0013 over 0x11223344 -> one READ cycle, then WRITE with mem_data_in 0xAA223344. Total latency 3 cycles.
- Signed byte load at 0x0013 of 0x80223344 -> resp_rdata 0xFFFFFF80. The unsigned load returns 0x00000080.
- Halfword load at 0x0012 of 0x8001BEEF with req_signed = 1 -> resp_rdata 0xFFFF8001.
- Misaligned word at 0x0011:
  - with MAU_MISALIGN_TRAP_EN defined -> resp_error = 1 after 1 cycle, mem_en never asserted;
  - without the macro -> access to word 0x0004.
- mem_miss held high for 2 cycles during READ, then Rst pulsed low mid-WRITE:
  - miss -> READ is held for 2 extra cycles with mem_address stable;
  - reset -> outputs return to their reset values immediately and no resp_valid is issued.
